// File: rtl/colordet_pkg.sv
// Shared types and constants for the colour-dominance highlighter.
package colordet_pkg;

    typedef enum logic [1:0] {
        MODE_R      = 2'b00,
        MODE_G      = 2'b01,
        MODE_B      = 2'b10,
        MODE_BYPASS = 2'b11
    } mode_e;

    localparam int THRESH_RST_DEF = 82906;

    // c * d1 * d2 with an unsigned DW-bit c and two signed DW+1-bit differences
    function automatic int score_w(input int dw);
        return 3 * dw + 2;
    endfunction

endpackage

// File: rtl/color_score.sv
// Dominance score datapath: differences in S1, full-width product and dominance flag in S2.
module color_score
    import colordet_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                          clk,
    input  logic [DW-1:0]                 c_p0,
    input  logic [DW-1:0]                 a_p0,
    input  logic [DW-1:0]                 b_p0,
    output logic signed [score_w(DW)-1:0] score_p2,
    output logic                          dom_p2
);

    localparam int SW = score_w(DW);

    logic signed [DW:0]   d1_p0, d2_p0;
    logic signed [DW:0]   d1_p1, d2_p1;
    logic [DW-1:0]        c_p1;
    logic signed [SW-1:0] c_ext_p1, d1_ext_p1, d2_ext_p1;

    assign d1_p0 = $signed({1'b0, c_p0}) - $signed({1'b0, a_p0});
    assign d2_p0 = $signed({1'b0, b_p0}) * 0 + $signed({1'b0, c_p0}) - $signed({1'b0, b_p0});

    // ---- S1: differences and target component ----
    always_ff @(posedge clk) begin
        d1_p1 <= d1_p0;
        d2_p1 <= d2_p0;
        c_p1  <= c_p0;
    end

    assign c_ext_p1  = $signed({{(SW-DW){1'b0}}, c_p1});
    assign d1_ext_p1 = {{(SW-DW-1){d1_p1[DW]}}, d1_p1};
    assign d2_ext_p1 = {{(SW-DW-1){d2_p1[DW]}}, d2_p1};

    // ---- S2: exact product and strict dominance ----
    always_ff @(posedge clk) begin
        score_p2 <= c_ext_p1 * d1_ext_p1 * d2_ext_p1;
        dom_p2   <= (d1_p1 > 0) && (d2_p1 > 0);
    end

endmodule

// File: rtl/color_highlight_pipe.sv
// Three-stage colour-dominance highlighter with loadable threshold and per-frame hit counter.
module color_highlight_pipe
    import colordet_pkg::*;
#(
    parameter int DW         = 8,
    parameter int THRESH_RST = THRESH_RST_DEF,
    parameter int GAIN_SHIFT = 2,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ctrl,
    input  logic [3*DW:0]    thresh_in,
    input  logic             thresh_load,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [DW-1:0]    in_r,
    input  logic [DW-1:0]    in_g,
    input  logic [DW-1:0]    in_b,
    output logic             out_valid,
    output logic [DW-1:0]    out_r,
    output logic [DW-1:0]    out_g,
    output logic [DW-1:0]    out_b,
    output logic             out_hit,
    output logic [CNT_W-1:0] frame_hits
);

    localparam int TW = 3 * DW + 1;
    localparam int SW = score_w(DW);

    // Components whose top GAIN_SHIFT bits are clear shift up losslessly; others clip
    function automatic logic [DW-1:0] sat_gain(input logic [DW-1:0] x);
        if (x[DW-1 -: GAIN_SHIFT] == '0)
            return x << GAIN_SHIFT;
        else
            return '1;
    endfunction

    mode_e                mode_p0, mode_p1, mode_p2;
    logic [DW-1:0]        c_p0, a_p0, b_p0;
    logic signed [TW-1:0] thresh;
    logic signed [TW-1:0] thresh_p1, thresh_p2;
    logic                 vld_p1, vld_p2;
    logic                 sof_p1, sof_p2;
    logic [DW-1:0]        r_p1, g_p1, b_p1;
    logic [DW-1:0]        r_p2, g_p2, b_p2;
    logic signed [SW-1:0] score_p2;
    logic                 dom_p2;
    logic                 hit_p2;
    logic [CNT_W-1:0]     hit_cnt;

    assign mode_p0 = mode_e'(ctrl);

    always_comb begin
        c_p0 = in_r;
        a_p0 = in_g;
        b_p0 = in_b;
        case (mode_p0)
            MODE_G: begin
                c_p0 = in_g;
                a_p0 = in_r;
                b_p0 = in_b;
            end
            MODE_B: begin
                c_p0 = in_b;
                a_p0 = in_r;
                b_p0 = in_g;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            thresh <= TW'(THRESH_RST);
        else if (thresh_load)
            thresh <= thresh_in;
    end

    color_score #(.DW(DW)) u_score (
        .clk      (clk),
        .c_p0     (c_p0),
        .a_p0     (a_p0),
        .b_p0     (b_p0),
        .score_p2 (score_p2),
        .dom_p2   (dom_p2)
    );

    // ---- S1: pixel, mode, sof and the threshold in force when the pixel arrived ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            sof_p1 <= in_valid & in_sof;
        end
    end

    always_ff @(posedge clk) begin
        mode_p1   <= mode_p0;
        r_p1      <= in_r;
        g_p1      <= in_g;
        b_p1      <= in_b;
        thresh_p1 <= thresh;
    end

    // ---- S2: companions of the score ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            sof_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            sof_p2 <= sof_p1;
        end
    end

    always_ff @(posedge clk) begin
        mode_p2   <= mode_p1;
        r_p2      <= r_p1;
        g_p2      <= g_p1;
        b_p2      <= b_p1;
        thresh_p2 <= thresh_p1;
    end

    assign hit_p2 = vld_p2 && dom_p2 && (score_p2 > thresh_p2) && (mode_p2 != MODE_BYPASS);

    // ---- S3: compare result, highlighted pixel and frame counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_hit    <= 1'b0;
            out_r      <= '0;
            out_g      <= '0;
            out_b      <= '0;
            frame_hits <= '0;
            hit_cnt    <= '0;
        end else begin
            out_valid <= vld_p2;
            out_hit   <= hit_p2;
            if (vld_p2) begin
                out_r <= hit_p2 ? sat_gain(r_p2) : r_p2;
                out_g <= hit_p2 ? sat_gain(g_p2) : g_p2;
                out_b <= hit_p2 ? sat_gain(b_p2) : b_p2;
                if (sof_p2) begin
                    frame_hits <= hit_cnt;
                    hit_cnt    <= CNT_W'(hit_p2);
                end else if (hit_p2 && (hit_cnt != '1)) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_color_highlight_pipe.sv
// Directed bench for color_highlight_pipe with hand-computed expected pixels and counts.
module tb_color_highlight_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctrl;
    logic [24:0] thresh_in;
    logic        thresh_load;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_r, in_g, in_b;
    logic        out_valid;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_hit;
    logic [19:0] frame_hits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    color_highlight_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl        (ctrl),
        .thresh_in   (thresh_in),
        .thresh_load (thresh_load),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_r        (in_r),
        .in_g        (in_g),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .out_hit     (out_hit),
        .frame_hits  (frame_hits)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic sof);
        ctrl     = c;
        in_r     = r;
        in_g     = g;
        in_b     = b;
        in_sof   = sof;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b expected 0", out_valid);
        end
        checks++;
        if (out_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_hit got %b expected 0", out_hit);
        end
        checks++;
        if ({out_r, out_g, out_b} !== 24'h0) begin
            errors++;
            $display("FAIL reset_pixel got (%0d,%0d,%0d) expected (0,0,0)", out_r, out_g, out_b);
        end
        checks++;
        if (frame_hits !== 20'd0) begin
            errors++;
            $display("FAIL reset_frame_hits got %0d expected 0", frame_hits);
        end
        rst_n = 1'b1;
        step();
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid got %b expected 0", out_valid);
        end
    endtask

    // Frames: [sof miss, hit, hit, hit] [sof hit, hit] [sof miss]
    task automatic test_counter();
        int          n;
        logic        t_sof [7];
        logic [7:0]  t_r [7], t_g [7], t_b [7];
        logic [7:0]  e_r [7], e_g [7], e_b [7];
        logic        e_hit [7];
        logic [19:0] e_fh [7];
        n = 7;
        for (int i = 0; i < 7; i++) begin
            t_sof[i] = 1'b0;
            t_r[i] = 8'd200; t_g[i] = 8'd50; t_b[i] = 8'd50;
            e_r[i] = 8'd255; e_g[i] = 8'd200; e_b[i] = 8'd200;
            e_hit[i] = 1'b1;
        end
        t_sof[0] = 1'b1; t_sof[4] = 1'b1; t_sof[6] = 1'b1;
        t_r[0] = 8'd100; t_g[0] = 8'd90; t_b[0] = 8'd90;
        e_r[0] = 8'd100; e_g[0] = 8'd90; e_b[0] = 8'd90; e_hit[0] = 1'b0;
        t_r[6] = 8'd100; t_g[6] = 8'd90; t_b[6] = 8'd90;
        e_r[6] = 8'd100; e_g[6] = 8'd90; e_b[6] = 8'd90; e_hit[6] = 1'b0;
        e_fh[0] = 20'd0; e_fh[1] = 20'd0; e_fh[2] = 20'd0; e_fh[3] = 20'd0;
        e_fh[4] = 20'd3; e_fh[5] = 20'd3; e_fh[6] = 20'd2;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) drive(2'b00, t_r[i], t_g[i], t_b[i], t_sof[i]);
            else idle();
            step();
            if (i >= 2) begin
                checks++;
                if ({out_valid, out_hit, out_r, out_g, out_b, frame_hits} !==
                    {1'b1, e_hit[i-2], e_r[i-2], e_g[i-2], e_b[i-2], e_fh[i-2]}) begin
                    errors++;
                    $display("FAIL counter_px%0d got v=%b h=%b (%0d,%0d,%0d) fh=%0d expected v=1 h=%b (%0d,%0d,%0d) fh=%0d",
                             i-2, out_valid, out_hit, out_r, out_g, out_b, frame_hits,
                             e_hit[i-2], e_r[i-2], e_g[i-2], e_b[i-2], e_fh[i-2]);
                end
            end
        end
        step();
    endtask

    task automatic test_red_hit();
        drive(2'b00, 8'd200, 8'd50, 8'd50, 1'b0);
        step();
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL red_latency out_valid got %b expected 0 after two edges", out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b1, 8'd255, 8'd200, 8'd200}) begin
            errors++;
            $display("FAIL red_hit got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=1 (255,200,200)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
    endtask

    task automatic test_below_thresh();
        drive(2'b00, 8'd100, 8'd90, 8'd90, 1'b0);
        step();
        idle();
        step();
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd100, 8'd90, 8'd90}) begin
            errors++;
            $display("FAIL below_thresh got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=0 (100,90,90)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
    endtask

    task automatic test_dominance();
        // Red is the minimum: score 10*(-190)*(-190) is positive and above threshold
        drive(2'b00, 8'd10, 8'd200, 8'd200, 1'b0);
        step();
        idle();
        step();
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd10, 8'd200, 8'd200}) begin
            errors++;
            $display("FAIL dom_min got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=0 (10,200,200)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
        drive(2'b00, 8'd50, 8'd200, 8'd50, 1'b0);
        step();
        idle();
        step();
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd50, 8'd200, 8'd50}) begin
            errors++;
            $display("FAIL dom_red got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=0 (50,200,50)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
        drive(2'b01, 8'd50, 8'd200, 8'd50, 1'b0);
        step();
        idle();
        step();
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b1, 8'd200, 8'd255, 8'd200}) begin
            errors++;
            $display("FAIL dom_green got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=1 (200,255,200)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
    endtask

    task automatic test_bypass();
        drive(2'b11, 8'd255, 8'd0, 8'd0, 1'b0);
        step();
        idle();
        step();
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd255, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL bypass got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=0 (255,0,0)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
    endtask

    task automatic test_back_to_back();
        int         n;
        logic [1:0] t_c [7];
        logic [7:0] t_r [7], t_g [7], t_b [7];
        logic [7:0] e_r [7], e_g [7], e_b [7];
        logic       e_hit [7];
        n = 7;
        t_c[0] = 2'b00; t_r[0] = 8'd200; t_g[0] = 8'd50;  t_b[0] = 8'd50;
        e_r[0] = 8'd255; e_g[0] = 8'd200; e_b[0] = 8'd200; e_hit[0] = 1'b1;
        t_c[1] = 2'b01; t_r[1] = 8'd50;  t_g[1] = 8'd200; t_b[1] = 8'd50;
        e_r[1] = 8'd200; e_g[1] = 8'd255; e_b[1] = 8'd200; e_hit[1] = 1'b1;
        t_c[2] = 2'b10; t_r[2] = 8'd30;  t_g[2] = 8'd40;  t_b[2] = 8'd60;
        e_r[2] = 8'd30;  e_g[2] = 8'd40;  e_b[2] = 8'd60;  e_hit[2] = 1'b0;
        t_c[3] = 2'b10; t_r[3] = 8'd20;  t_g[3] = 8'd20;  t_b[3] = 8'd100;
        e_r[3] = 8'd80;  e_g[3] = 8'd80;  e_b[3] = 8'd255; e_hit[3] = 1'b1;
        t_c[4] = 2'b11; t_r[4] = 8'd255; t_g[4] = 8'd0;   t_b[4] = 8'd0;
        e_r[4] = 8'd255; e_g[4] = 8'd0;   e_b[4] = 8'd0;   e_hit[4] = 1'b0;
        t_c[5] = 2'b01; t_r[5] = 8'd63;  t_g[5] = 8'd128; t_b[5] = 8'd64;
        e_r[5] = 8'd252; e_g[5] = 8'd255; e_b[5] = 8'd255; e_hit[5] = 1'b1;
        t_c[6] = 2'b00; t_r[6] = 8'd150; t_g[6] = 8'd150; t_b[6] = 8'd0;
        e_r[6] = 8'd150; e_g[6] = 8'd150; e_b[6] = 8'd0;   e_hit[6] = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) drive(t_c[i], t_r[i], t_g[i], t_b[i], 1'b0);
            else idle();
            step();
            if (i >= 2) begin
                checks++;
                if ({out_valid, out_hit, out_r, out_g, out_b} !==
                    {1'b1, e_hit[i-2], e_r[i-2], e_g[i-2], e_b[i-2]}) begin
                    errors++;
                    $display("FAIL b2b_px%0d got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=%b (%0d,%0d,%0d)",
                             i-2, out_valid, out_hit, out_r, out_g, out_b,
                             e_hit[i-2], e_r[i-2], e_g[i-2], e_b[i-2]);
                end
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_thresh_load();
        drive(2'b00, 8'd101, 8'd100, 8'd100, 1'b0);
        thresh_in   = 25'd0;
        thresh_load = 1'b1;
        step();
        thresh_load = 1'b0;
        drive(2'b00, 8'd101, 8'd100, 8'd100, 1'b0);
        step();
        idle();
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd101, 8'd100, 8'd100}) begin
            errors++;
            $display("FAIL thresh_old got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=0 (101,100,100)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b1, 8'd255, 8'd255, 8'd255}) begin
            errors++;
            $display("FAIL thresh_new got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=1 (255,255,255)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
        // Score 101 equal to threshold must not hit; threshold 100 must
        thresh_in   = 25'd101;
        thresh_load = 1'b1;
        step();
        thresh_load = 1'b0;
        drive(2'b00, 8'd101, 8'd100, 8'd100, 1'b0);
        step();
        idle();
        step();
        step();
        checks++;
        if (out_hit !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL thresh_equal got v=%b h=%b expected v=1 h=0", out_valid, out_hit);
        end
        thresh_in   = 25'd100;
        thresh_load = 1'b1;
        step();
        thresh_load = 1'b0;
        drive(2'b00, 8'd101, 8'd100, 8'd100, 1'b0);
        step();
        idle();
        step();
        step();
        checks++;
        if (out_hit !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL thresh_below_score got v=%b h=%b expected v=1 h=1", out_valid, out_hit);
        end
    endtask

    task automatic test_mid_reset();
        logic stale;
        thresh_in   = 25'd0;
        thresh_load = 1'b1;
        step();
        thresh_load = 1'b0;
        drive(2'b00, 8'd200, 8'd50, 8'd50, 1'b1);
        step();
        drive(2'b00, 8'd200, 8'd50, 8'd50, 1'b0);
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || frame_hits === 20'd0) begin
            errors++;
            $display("FAIL prereset_state got v=%b fh=%0d expected v=1 fh nonzero", out_valid, frame_hits);
        end
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_hit, frame_hits} !== {1'b0, 1'b0, 20'd0}) begin
            errors++;
            $display("FAIL midreset_async got v=%b h=%b fh=%0d expected v=0 h=0 fh=0",
                     out_valid, out_hit, frame_hits);
        end
        checks++;
        if ({out_r, out_g, out_b} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_pixel got (%0d,%0d,%0d) expected (0,0,0)", out_r, out_g, out_b);
        end
        step();
        step();
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale got stale=%b expected 0", stale);
        end
        // Threshold back at 82906: score 10000 must not hit
        drive(2'b00, 8'd100, 8'd90, 8'd90, 1'b0);
        step();
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL postreset_latency out_valid got %b expected 0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_hit, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd100, 8'd90, 8'd90}) begin
            errors++;
            $display("FAIL postreset_thresh got v=%b h=%b (%0d,%0d,%0d) expected v=1 h=0 (100,90,90)",
                     out_valid, out_hit, out_r, out_g, out_b);
        end
        drive(2'b00, 8'd200, 8'd50, 8'd50, 1'b0);
        step();
        drive(2'b00, 8'd100, 8'd90, 8'd90, 1'b1);
        step();
        idle();
        step();
        step();
        checks++;
        if (frame_hits !== 20'd1) begin
            errors++;
            $display("FAIL postreset_count got fh=%0d expected 1", frame_hits);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        ctrl        = 2'b00;
        thresh_in   = 25'd0;
        thresh_load = 1'b0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_r        = 8'd0;
        in_g        = 8'd0;
        in_b        = 8'd0;
        test_reset();
        test_counter();
        test_red_hit();
        test_below_thresh();
        test_dominance();
        test_bypass();
        test_back_to_back();
        test_thresh_load();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_highlight_pipe.md
# color_highlight_pipe

Pipelined, parametrised successor to the combinational colour-dominance highlighter in the D8M video path. The block sits between the camera RGB stream and the VGA output stage. It scores each pixel for red, green or blue dominance against a run-time loadable threshold, and brightens pixels that pass. It also counts highlighted pixels per frame so software can read them.

## Interface
Parameters:
- DW, 8: bits per colour component.
- THRESH_RST, 82906 (0x143DA): threshold value loaded at reset.
- GAIN_SHIFT, 2: left-shift applied to highlighted components.
- CNT_W, 20: width of the per-frame hit counter.

Ports:
- clk, in, 1: pixel clock; the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- ctrl, in, 2: mode. 00 = red, 01 = green, 10 = blue, 11 = bypass.
- thresh_in, in, 3*DW+1: new threshold value.
- thresh_load, in, 1: loads thresh_in into the threshold register.
- in_valid, in, 1: input pixel valid.
- in_sof, in, 1: start of frame; qualified by in_valid.
- in_r / in_g / in_b, in, DW each: input pixel.
- out_valid, out, 1: output pixel valid.
- out_r / out_g / out_b, out, DW each: output pixel.
- out_hit, out, 1: output pixel was highlighted.
- frame_hits, out, CNT_W: hit count of the previous completed frame.

## Operation
- Target component c is selected by ctrl; a and b are the other two components. ctrl is sampled with the pixel in stage 1 and travels with it.
- Score:
  - d1 = c − a and d2 = c − b, each signed DW+1 bits.
  - score = c × d1 × d2, signed 3*DW+2 bits, with no truncation.
- Hit condition, all of the following: d1 > 0, d2 > 0, score > thresh (signed compare), and ctrl ≠ 11.
  - The dominance check (d1 > 0, d2 > 0) is mandatory. A pixel whose target component is the minimum must not hit, even though its score is positive.
- Highlight, per component x:
  - if x[DW-1 : DW-GAIN_SHIFT] == 0, output x << GAIN_SHIFT;
  - otherwise output all-ones (saturate).
- On a hit all three components are highlighted. With no hit the pixel passes through unchanged.
- Threshold register:
  - reset value THRESH_RST;
  - thresh_load=1 captures thresh_in at the clock edge;
  - the new value applies to pixels entering stage 1 on the following cycle.
- Hit counter:
  - increments on every out_valid & out_hit and saturates at all-ones;
  - when the pixel carrying sof reaches the output, frame_hits takes the count so far (excluding the sof pixel), and the counter restarts at that pixel's hit (0 or 1).
- No backpressure: the stream is continuous. in_valid=0 produces a bubble that propagates to out_valid.

## Timing
- Latency is fixed at 3 cycles; throughput is one pixel per clock.
  - S1 registers d1, d2, c, the pixel, ctrl and sof.
  - S2 registers the score and the dominance flag.
  - S3 registers the compare result, the muxed output and the counter update.
- Reset values: out_valid=0, out_hit=0, out_r/g/b=0, frame_hits=0, internal counter=0, thresh=THRESH_RST, all stage valids=0.
- Reset asserted mid-frame clears all of these immediately. The first valid output after deassertion comes 3 cycles after the first in_valid.
- thresh_load in the same cycle as a pixel: that pixel uses the old threshold.
- sof pixel that is also a hit when the counter is saturated: frame_hits takes the saturated value and the counter becomes 1.
- ctrl changing mid-frame is legal and takes effect per pixel.

## Structure
- Package colordet_pkg:
  - mode enum: MODE_R, MODE_G, MODE_B, MODE_BYPASS;
  - function score_w(DW) = 3*DW+2;
  - THRESH_RST default constant.
- Sub-module color_score: S1–S2 datapath. Takes the selected c, a and b; produces the registered score and dominance flag with 2-cycle latency.
- The top level handles channel selection, threshold register, S3 compare/highlight, valid/sof pipeline and counter.

## Test plan
- ctrl=00, pixel (200,50,50): score 4,500,000 > 82906, so 3 cycles later out = (255,200,200), out_hit=1.
- ctrl=00, pixel (100,90,90): score 10,000 is below threshold, so out = (100,90,90), out_hit=0.
- ctrl=00, pixel (50,200,50): d1 < 0, so no hit despite positive score; out = (50,200,50). Same pixel with ctrl=01 gives (200,255,200) with a hit.
- ctrl=11, pixel (255,0,0): bypass, so out = (255,0,0), out_hit=0.
- Threshold load of 0 in the same cycle as pixel (101,100,100), then the same pixel again:
  - first pixel (score 101, old threshold 82906): no hit;
  - second pixel: hit, out = (255,255,255) since every component has a top bit set.
- Counter and reset:
  - frame of 4 pixels with 3 hits, then sof: frame_hits=3;
  - rst_n pulsed low mid-pipeline: out_valid=0 and frame_hits=0 at once, and no stale pixels emerge after release.
